sram_fifo_ctrl: RTL

Controller that turns the dual-port sram_memory into a streaming FIFO for DVS event words. Port A of the SRAM is the write side, fed by an upstream valid/ready event stream. Port B is the read side, which drains to a downstream valid/ready consumer. A 2-entry output skid buffer absorbs the SRAM's 1-cycle read latency, so throughput is 1 word/cycle. The SRAM is instantiated beside this block; its wdata_b input is tied to 0 at that instantiation.

---
 rtl/sram_fifo_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: streams words through a dual-port SRAM (port A write, port B read)
// with a 2-entry skid buffer hiding the 1-cycle read latency.
`default_nettype none

module sram_fifo_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 2) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [LW-1:0]      level,
  output logic               ce_a,
  output logic               we_a,
  output logic [AW-1:0]      addr_a,
  output logic [WIDTH/8-1:0] wmask_a,
  output logic [WIDTH-1:0]   wdata_a,
  output logic               ce_b,
  output logic               we_b,
  output logic [AW-1:0]      addr_b,
  output logic [WIDTH/8-1:0] wmask_b,
  input  logic [WIDTH-1:0]   rdata_b
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mem_count_q, mem_count_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic [1:0]       buf_count_q, buf_count_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic             accept;
  logic             pop;
  logic             rd_go;
  logic             ret_vld;
  logic [1:0]       occ;
  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  // The returning SRAM word counts as a buffer entry in the cycle it arrives,
  // which gives the two-cycle accept-to-output latency.
  assign ret_vld   = rd_inflight_q && !flush;
  assign in_ready  = !rst && !flush && (mem_count_q < DEPTH_W);
  assign accept    = in_valid && in_ready;
  assign out_valid = (buf_count_q != 2'd0) || ret_vld;
  assign out_data  = (buf_count_q != 2'd0) ? buf0_q : (ret_vld ? rdata_b : buf0_q);
  assign pop       = out_valid && out_ready;
  assign occ       = buf_count_q + {1'b0, ret_vld};
  assign rd_go     = !flush && (mem_count_q != '0) && ((occ - {1'b0, pop}) < 2'd2);

  assign ce_a    = accept;
  assign we_a    = accept;
  assign addr_a  = wr_ptr_q;
  assign wdata_a = in_data;
  assign wmask_a = '1;
  assign ce_b    = rd_go;
  assign we_b    = 1'b0;
  assign addr_b  = rd_ptr_q;
  assign wmask_b = '0;

  assign level = LW'(mem_count_q) + LW'(rd_inflight_q) + LW'(buf_count_q);

  assign ent0 = (buf_count_q != 2'd0) ? buf0_q : rdata_b;
  assign ent1 = (buf_count_q == 2'd2) ? buf1_q : rdata_b;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_count_d   = mem_count_q;
    rd_inflight_d = rd_inflight_q;
    buf_count_d   = buf_count_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      mem_count_d   = '0;
      rd_inflight_d = 1'b0;
      buf_count_d   = 2'd0;
      buf0_d        = '0;
      buf1_d        = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_go)  rd_ptr_d = rd_ptr_q + AW'(1);
      mem_count_d   = mem_count_q + (AW+1)'(accept) - (AW+1)'(rd_go);
      rd_inflight_d = rd_go;
      buf_count_d   = occ - {1'b0, pop};
      // Entries in order are ent0, ent1; a pop shifts the second one to the head.
      if (pop) begin
        buf0_d = ent1;
      end else if (ret_vld) begin
        buf0_d = ent0;
        buf1_d = ent1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      buf_count_q   <= 2'd0;
      buf0_q        <= '0;
      buf1_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
      buf_count_q   <= buf_count_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
    end
  end

endmodule

`default_nettype wire
